// File: rtl/wait_timer_mc.sv
// Multi-channel programmable delay timer: a rising start edge arms a channel,
// which pulses out for one cycle after Deff clocks (one-shot or periodic).
module wait_timer_mc #(
  parameter int CHANNELS  = 4,
  parameter int CNT_W     = 8,
  parameter int RETRIGGER = 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [CHANNELS-1:0]       start,
  input  logic [CHANNELS-1:0]       cancel,
  input  logic [CHANNELS-1:0]       periodic,
  input  logic [CHANNELS*CNT_W-1:0] tick,
  output logic [CHANNELS-1:0]       out,
  output logic [CHANNELS-1:0]       busy
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    logic [0:0]       state_r;
    logic             start_q_r;
    logic             mode_r;
    logic             out_r;
    logic             busy_r;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] dly_r;
    logic [CNT_W-1:0] deff_s;
    logic             edge_s;
    logic             expire_s;
    logic             accept_s;

    // Effective delay, edge detect and start acceptance for this channel
    always_comb begin
      deff_s   = (dly_r == {CNT_W{1'b0}}) ? CNT_W'(1) : dly_r;
      edge_s   = start[g] & ~start_q_r;
      expire_s = (cnt_r == (deff_s - CNT_W'(1)));
      // A running channel only takes a new start when retriggering is enabled
      accept_s = edge_s & ((state_r == ST_IDLE) | (RETRIGGER != 0));
    end

    // Channel state, counter, latched settings and registered outputs
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        state_r   <= ST_IDLE;
        start_q_r <= 1'b0;
        mode_r    <= 1'b0;
        out_r     <= 1'b0;
        busy_r    <= 1'b0;
        cnt_r     <= {CNT_W{1'b0}};
        dly_r     <= CNT_W'(1);
      end else begin
        start_q_r <= start[g];
        if (cancel[g]) begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
          out_r   <= 1'b0;
          cnt_r   <= {CNT_W{1'b0}};
        end else if (accept_s) begin
          state_r <= ST_RUN;
          busy_r  <= 1'b1;
          out_r   <= 1'b0;
          cnt_r   <= {CNT_W{1'b0}};
          dly_r   <= tick[g*CNT_W +: CNT_W];
          mode_r  <= periodic[g];
        end else begin
          case (state_r)
            ST_RUN: begin
              if (expire_s) begin
                out_r <= 1'b1;
                cnt_r <= {CNT_W{1'b0}};
                if (!mode_r) begin
                  state_r <= ST_IDLE;
                  busy_r  <= 1'b0;
                end
              end else begin
                out_r <= 1'b0;
                cnt_r <= cnt_r + CNT_W'(1);
              end
            end
            ST_IDLE: begin
              out_r <= 1'b0;
            end
            default: begin
              state_r <= ST_IDLE;
              busy_r  <= 1'b0;
              out_r   <= 1'b0;
              cnt_r   <= {CNT_W{1'b0}};
            end
          endcase
        end
      end
    end

    assign out[g]  = out_r;
    assign busy[g] = busy_r;
  end

endmodule

// File: tb/tb_wait_timer_mc.sv
// Self-checking bench for wait_timer_mc: a deadline-based channel model checked
// every cycle, plus literal pulse-time checks for the directed scenarios.
module tb_wait_timer_mc;

  logic        clk;
  logic        rst_n;
  logic [3:0]  start;
  logic [3:0]  cancel;
  logic [3:0]  periodic;
  logic [31:0] tick;
  logic [3:0]  out_a, busy_a;  // RETRIGGER = 1
  logic [3:0]  out_b, busy_b;  // RETRIGGER = 0

  wait_timer_mc #(.CHANNELS(4), .CNT_W(8), .RETRIGGER(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start), .cancel(cancel),
    .periodic(periodic), .tick(tick), .out(out_a), .busy(busy_a));

  wait_timer_mc #(.CHANNELS(4), .CNT_W(8), .RETRIGGER(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start), .cancel(cancel),
    .periodic(periodic), .tick(tick), .out(out_b), .busy(busy_b));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int ncyc  = 0;

  // Model state per instance k (0 = retrigger, 1 = no retrigger) and channel
  bit m_act  [2][4];
  bit m_mode [2][4];
  bit m_out  [2][4];
  bit m_prev [2][4];
  int m_dl   [2][4];
  int m_per  [2][4];

  // Observed pulse history from the DUTs
  int pcnt [2][4];
  int plast[2][4];

  // Model: an accepted start at edge n schedules expiry at n+Deff
  initial begin
    bit e;
    forever begin
      @(posedge clk);
      ncyc++;
      for (int k = 0; k < 2; k++) begin
        for (int i = 0; i < 4; i++) begin
          if (!rst_n) begin
            m_act[k][i] = 1'b0; m_out[k][i] = 1'b0; m_prev[k][i] = 1'b0; m_mode[k][i] = 1'b0;
          end else begin
            e = start[i] && !m_prev[k][i];
            m_prev[k][i] = start[i];
            if (cancel[i]) begin
              m_act[k][i] = 1'b0; m_out[k][i] = 1'b0;
            end else if (e && (!m_act[k][i] || k == 0)) begin
              m_per[k][i]  = (tick[i*8 +: 8] == 8'd0) ? 1 : int'(tick[i*8 +: 8]);
              m_dl[k][i]   = ncyc + m_per[k][i];
              m_mode[k][i] = periodic[i];
              m_act[k][i]  = 1'b1;
              m_out[k][i]  = 1'b0;
            end else if (m_act[k][i] && ncyc == m_dl[k][i]) begin
              m_out[k][i] = 1'b1;
              if (m_mode[k][i]) m_dl[k][i] = m_dl[k][i] + m_per[k][i];
              else m_act[k][i] = 1'b0;
            end else begin
              m_out[k][i] = 1'b0;
            end
          end
        end
      end
    end
  end

  // Compare process: every cycle, both instances, plus pulse logging
  initial begin
    logic [3:0] eo, eb, ao, ab;
    forever begin
      @(negedge clk);
      if (ncyc > 0) begin
        for (int k = 0; k < 2; k++) begin
          for (int i = 0; i < 4; i++) begin
            eo[i] = m_out[k][i];
            eb[i] = m_act[k][i];
          end
          ao = (k == 0) ? out_a : out_b;
          ab = (k == 0) ? busy_a : busy_b;
          n_cmp++;
          if (ao !== eo) begin
            n_err++;
            $display("FAIL out[inst%0d] edge %0d: got %b expected %b", k, ncyc, ao, eo);
          end
          n_cmp++;
          if (ab !== eb) begin
            n_err++;
            $display("FAIL busy[inst%0d] edge %0d: got %b expected %b", k, ncyc, ab, eb);
          end
          for (int i = 0; i < 4; i++) begin
            if (ao[i] === 1'b1) begin
              pcnt[k][i]++;
              plast[k][i] = ncyc;
            end
          end
        end
      end
    end
  end

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic clr_counts();
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < 4; i++) begin
        pcnt[k][i] = 0;
        plast[k][i] = -1;
      end
  endtask

  task automatic wait_until(input int target);
    int guard = 0;
    while (ncyc < target && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    check("wait_until_target", ncyc, target);
  endtask

  int e0;

  initial begin
    rst_n = 1'b0; start = 4'b0; cancel = 4'b0; periodic = 4'b0; tick = 32'd0;
    clr_counts();
    repeat (3) @(negedge clk);
    check("reset_out_a", int'(out_a), 0);
    check("reset_busy_a", int'(busy_a), 0);
    check("reset_busy_b", int'(busy_b), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Single shot, CH0 tick=5
    clr_counts();
    tick[7:0] = 8'd5; periodic[0] = 1'b0; start[0] = 1'b1;
    @(negedge clk); e0 = ncyc; start[0] = 1'b0;
    check("single_busy_after_start", int'(busy_a[0]), 1);
    wait_until(e0 + 8);
    check("single_pulse_edge", plast[0][0], e0 + 5);
    check("single_pulse_count", pcnt[0][0], 1);
    check("single_others_quiet", pcnt[0][1] + pcnt[0][2] + pcnt[0][3], 0);

    // Periodic CH1 tick=3, cancel sampled at E0+7
    clr_counts();
    tick[15:8] = 8'd3; periodic[1] = 1'b1; start[1] = 1'b1;
    @(negedge clk); e0 = ncyc; start[1] = 1'b0;
    wait_until(e0 + 6);
    cancel[1] = 1'b1;
    @(negedge clk); cancel[1] = 1'b0;
    wait_until(e0 + 12);
    check("periodic_pulse_count", pcnt[0][1], 2);
    check("periodic_last_pulse", plast[0][1], e0 + 6);
    check("periodic_busy_after_cancel", int'(busy_a[1]), 0);
    periodic[1] = 1'b0;

    // tick=0 and tick=1 one-shot on CH2/CH3
    clr_counts();
    tick[23:16] = 8'd0; tick[31:24] = 8'd1; start[3:2] = 2'b11;
    @(negedge clk); e0 = ncyc; start[3:2] = 2'b00;
    wait_until(e0 + 4);
    check("tick0_pulse_edge", plast[0][2], e0 + 1);
    check("tick1_pulse_edge", plast[0][3], e0 + 1);

    // tick=255 on CH0
    clr_counts();
    tick[7:0] = 8'd255; start[0] = 1'b1;
    @(negedge clk); e0 = ncyc; start[0] = 1'b0;
    wait_until(e0 + 258);
    check("tick255_pulse_edge", plast[0][0], e0 + 255);
    check("tick255_pulse_count", pcnt[0][0], 1);

    // Retrigger: tick=4, second start edge at E0+2
    clr_counts();
    tick[7:0] = 8'd4; start[0] = 1'b1;
    @(negedge clk); e0 = ncyc; start[0] = 1'b0;
    wait_until(e0 + 1);
    start[0] = 1'b1;
    @(negedge clk); start[0] = 1'b0;
    wait_until(e0 + 9);
    check("retrig1_pulse_edge", plast[0][0], e0 + 6);
    check("retrig1_pulse_count", pcnt[0][0], 1);
    check("retrig0_pulse_edge", plast[1][0], e0 + 4);
    check("retrig0_pulse_count", pcnt[1][0], 1);

    // Cancel and start on the same edge in IDLE
    clr_counts();
    tick[15:8] = 8'd2; start[1] = 1'b1; cancel[1] = 1'b1;
    @(negedge clk); start[1] = 1'b0; cancel[1] = 1'b0;
    check("cancel_start_busy", int'(busy_a[1]), 0);
    repeat (5) @(negedge clk);
    check("cancel_start_no_pulse", pcnt[0][1], 0);

    // Four channels together, ticks 1..4
    clr_counts();
    tick = {8'd4, 8'd3, 8'd2, 8'd1}; start = 4'b1111;
    @(negedge clk); e0 = ncyc; start = 4'b0000;
    wait_until(e0 + 6);
    for (int i = 0; i < 4; i++) check("four_ch_pulse_edge", plast[0][i], e0 + 1 + i);

    // Reset mid-run with start held high through release
    clr_counts();
    tick[23:16] = 8'd6; start[2] = 1'b1;
    @(negedge clk); e0 = ncyc; start[2] = 1'b0;
    wait_until(e0 + 1);
    rst_n = 1'b0; start[2] = 1'b1;
    @(negedge clk);
    check("midrst_busy", int'(busy_a), 0);
    check("midrst_out", int'(out_a), 0);
    @(negedge clk);
    rst_n = 1'b1;
    wait_until(e0 + 12);
    start[2] = 1'b0;
    check("post_reset_pulse_edge", plast[0][2], e0 + 10);
    check("post_reset_pulse_count", pcnt[0][2], 1);
    repeat (3) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
